// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's instruction-memory port, redirect input and
// decode-side output handshake. Signal names are from the fetch stage's
// point of view.
interface fetch_stage_if;
  // instruction memory request/grant/response
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  // control-flow redirect
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  // decode handshake
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  // fetch stage side
  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i
  );

  // memory / decode / branch-unit side
  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word-aligned
// request at a time, buffers the returned word with its PC in a single-entry
// output register, and flushes on redirect.
//
// Handshakes:
//  - imem: a request transfers on a cycle with imem_req_o & imem_gnt_i; the
//    address is held until that cycle. The response arrives on a later cycle
//    with imem_rvalid_i (exactly one response per granted request).
//  - decode: a word transfers on a cycle with valid_o & ready_i;
//    instr_o/pc_o/valid_o hold steady while valid_o & !ready_i.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fetch_stage_if.master bus,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_REQ  = 2'd0;  // request pending
  localparam logic [1:0] ST_WAIT = 2'd1;  // granted, response will be kept
  localparam logic [1:0] ST_DROP = 2'd2;  // granted, response will be discarded

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] out_pc_q;
  logic        valid_q;
  logic        req;
  logic        hs_imem;
  logic [31:0] redirect_target;

  // Only request when the output buffer is empty or being drained this cycle,
  // so a returning response always finds room.
  assign req             = !rst_i && (state_q == ST_REQ) && (!valid_q || bus.ready_i);
  assign hs_imem         = req && bus.imem_gnt_i;
  assign redirect_target = bus.redirect_pc_i & 32'hFFFF_FFFC;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = {pc_q[31:2], 2'b00};
  assign bus.instr_o     = instr_q;
  assign bus.pc_o        = out_pc_q;
  assign bus.valid_o     = valid_q;
  assign dbg_state_o     = state_q;

  // PC, fetch FSM and output buffer; redirect outranks everything but reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      instr_q  <= NOP;
      out_pc_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
      if (bus.redirect_i) begin
        pc_q    <= redirect_target;
        valid_q <= 1'b0;
        case (state_q)
          ST_REQ:  state_q <= hs_imem ? ST_DROP : ST_REQ;
          ST_WAIT: state_q <= bus.imem_rvalid_i ? ST_REQ : ST_DROP;
          ST_DROP: state_q <= bus.imem_rvalid_i ? ST_REQ : ST_DROP;
          default: state_q <= ST_REQ;
        endcase
      end else begin
        case (state_q)
          ST_REQ: begin
            // stray responses are ignored here
            if (hs_imem) begin
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (bus.imem_rvalid_i) begin
              instr_q  <= bus.imem_rdata_i;
              out_pc_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + 32'd4;
              state_q  <= ST_REQ;
            end
          end
          ST_DROP: begin
            if (bus.imem_rvalid_i) begin
              state_q <= ST_REQ;
            end
          end
          default: state_q <= ST_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming fetch, output stall,
// delayed grant, redirect flushes, PC wrap and reset during an outstanding
// request.
module tb_fetch_stage;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // clock / reset
  logic clk;
  logic rst;
  logic rst2;
  logic [1:0] st;
  logic [1:0] st2;

  int total;
  int bad;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state_o(st)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst2), .bus(bus2), .dbg_state_o(st2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance to just after the next rising edge; inputs are driven here and
  // outputs are checked #1 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      total++;
      if (bus.imem_req_o !== 1'b0 || bus.valid_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_req_valid cycle %0d: req=%b valid=%b, want 0 0", i, bus.imem_req_o, bus.valid_o);
      end
    end
    total++;
    if (bus.instr_o !== 32'h0000_0013 || bus.pc_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_out: instr=%h pc=%h, want 00000013 00000000", bus.instr_o, bus.pc_o);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] data [3];
    data[0] = 32'h0050_0093;
    data[1] = 32'h00A0_0113;
    data[2] = 32'h0020_81B3;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.imem_gnt_i = 1'b1;
      bus.imem_rvalid_i = 1'b0;
      #1;
      total++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'(4 * i)) begin
        bad++;
        $display("FAIL stream_req %0d: req=%b addr=%h, want 1 %h", i, bus.imem_req_o, bus.imem_addr_o, 32'(4 * i));
      end
      if (i > 0) begin
        total++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'(4 * (i - 1)) || bus.instr_o !== data[i-1]) begin
          bad++;
          $display("FAIL stream_out %0d: valid=%b pc=%h instr=%h, want 1 %h %h", i - 1, bus.valid_o, bus.pc_o, bus.instr_o, 32'(4 * (i - 1)), data[i-1]);
        end
      end
      tick();
      bus.imem_gnt_i = 1'b0;
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i = data[i];
      #1;
      total++;
      if (bus.imem_req_o !== 1'b0 || bus.valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stream_wait %0d: req=%b valid=%b, want 0 0", i, bus.imem_req_o, bus.valid_o);
      end
      tick();
      bus.imem_rvalid_i = 1'b0;
    end
    #1;
    total++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.instr_o !== data[2]) begin
      bad++;
      $display("FAIL stream_last: valid=%b pc=%h instr=%h, want 1 00000008 %h", bus.valid_o, bus.pc_o, bus.instr_o, data[2]);
    end
  endtask

  task automatic test_stall();
    // restart from PC 0 and fetch one word
    rst = 1'b1;
    bus.imem_gnt_i = 1'b0;
    tick();
    rst = 1'b0;
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h0050_0093;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h0050_0093 || bus.pc_o !== 32'h0 || bus.imem_req_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold %0d: valid=%b instr=%h pc=%h req=%b, want 1 00500093 00000000 0", i, bus.valid_o, bus.instr_o, bus.pc_o, bus.imem_req_o);
      end
      tick();
    end
    bus.ready_i = 1'b1;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin
      bad++;
      $display("FAIL stall_release: req=%b addr=%h, want 1 00000004", bus.imem_req_o, bus.imem_addr_o);
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || st !== ST_WAIT) begin
      bad++;
      $display("FAIL stall_drain: valid=%b state=%0d, want 0 %0d", bus.valid_o, st, ST_WAIT);
    end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h00A0_0113;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.instr_o !== 32'h00A0_0113) begin
      bad++;
      $display("FAIL stall_next: valid=%b pc=%h instr=%h, want 1 00000004 00a00113", bus.valid_o, bus.pc_o, bus.instr_o);
    end
  endtask

  task automatic test_gnt_delay();
    bus.imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8 || st !== ST_REQ) begin
        bad++;
        $display("FAIL gnt_hold %0d: req=%b addr=%h state=%0d, want 1 00000008 %0d", i, bus.imem_req_o, bus.imem_addr_o, st, ST_REQ);
      end
      tick();
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    total++;
    if (st !== ST_WAIT || bus.imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL gnt_wait: state=%0d req=%b, want %0d 0", st, bus.imem_req_o, ST_WAIT);
    end
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h0020_81B3;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.instr_o !== 32'h0020_81B3 || bus.imem_addr_o !== 32'hC) begin
      bad++;
      $display("FAIL gnt_data: valid=%b pc=%h instr=%h addr=%h, want 1 00000008 002081b3 0000000c", bus.valid_o, bus.pc_o, bus.instr_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_redirect();
    // redirect while waiting; response arrives two cycles later
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    total++;
    if (st !== ST_DROP || bus.valid_o !== 1'b0 || bus.imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait: state=%0d valid=%b req=%b, want %0d 0 0", st, bus.valid_o, bus.imem_req_o, ST_DROP);
    end
    tick();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      bad++;
      $display("FAIL redir_drop: valid=%b req=%b addr=%h, want 0 1 00000100", bus.valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
    // redirect coincident with the response
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'hCAFE_F00D;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.redirect_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || st !== ST_REQ || bus.imem_addr_o !== 32'h100) begin
      bad++;
      $display("FAIL redir_coinc: valid=%b state=%0d addr=%h, want 0 %0d 00000100", bus.valid_o, st, bus.imem_addr_o, ST_REQ);
    end
    // redirect in the same cycle as a grant
    bus.imem_gnt_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0202;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.redirect_i = 1'b0;
    #1;
    total++;
    if (st !== ST_DROP || bus.imem_addr_o !== 32'h200) begin
      bad++;
      $display("FAIL redir_gnt: state=%0d addr=%h, want %0d 00000200", st, bus.imem_addr_o, ST_DROP);
    end
    bus.imem_rvalid_i = 1'b1;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
      bad++;
      $display("FAIL redir_gnt_done: valid=%b req=%b addr=%h, want 0 1 00000200", bus.valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    #1;
    total++;
    if (bus.imem_req_o !== 1'b0 || st !== ST_REQ) begin
      bad++;
      $display("FAIL rstmid_req: req=%b state=%0d, want 0 %0d", bus.imem_req_o, st, ST_REQ);
    end
    rst = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h1234_5678;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_addr: req=%b addr=%h, want 1 00000000", bus.imem_req_o, bus.imem_addr_o);
    end
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 1'b0 || st !== ST_REQ || bus.instr_o !== 32'h0000_0013) begin
      bad++;
      $display("FAIL rstmid_late: valid=%b state=%0d instr=%h, want 0 %0d 00000013", bus.valid_o, st, bus.instr_o, ST_REQ);
    end
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    bus2.ready_i = 1'b1;
    bus2.imem_gnt_i = 1'b1;
    #1;
    total++;
    if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_first: req=%b addr=%h, want 1 fffffffc", bus2.imem_req_o, bus2.imem_addr_o);
    end
    tick();
    bus2.imem_gnt_i = 1'b0;
    bus2.imem_rvalid_i = 1'b1;
    bus2.imem_rdata_i = 32'h0000_006F;
    tick();
    bus2.imem_rvalid_i = 1'b0;
    #1;
    total++;
    if (bus2.valid_o !== 1'b1 || bus2.pc_o !== 32'hFFFF_FFFC || bus2.instr_o !== 32'h0000_006F || bus2.imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next: valid=%b pc=%h instr=%h addr=%h, want 1 fffffffc 0000006f 00000000", bus2.valid_o, bus2.pc_o, bus2.instr_o, bus2.imem_addr_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.ready_i       = 1'b0;
    bus2.imem_gnt_i    = 1'b0;
    bus2.imem_rvalid_i = 1'b0;
    bus2.imem_rdata_i  = 32'h0;
    bus2.redirect_i    = 1'b0;
    bus2.redirect_pc_i = 32'h0;
    bus2.ready_i       = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_gnt_delay();
    test_redirect();
    test_reset_mid();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
